// File: rtl/prio_scan_pkg.sv
// prio_scan_pkg: shared state type and index-width helper for the priority scan block
package prio_scan_pkg;

    typedef enum logic {IDLE, SCAN} state_t;

    // Index width that never collapses to zero, so a 1-bit index is still a legal vector
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// priority_encoder_n: combinational N-to-log2(N) priority encoder, MSB- or LSB-first
module priority_encoder_n
    import prio_scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = clog2_safe(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Later loop iterations overwrite earlier ones, so scan towards the winning end
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST && req[i]) idx = IDX_W'(i);
            if (!MSB_FIRST && req[WIDTH-1-i]) idx = IDX_W'(WIDTH-1-i);
        end
    end

endmodule

// File: rtl/priority_encoder_scan.sv
// priority_encoder_scan: captures a request vector and emits every set index in priority order; PRIO_SCAN_POPCNT_EN adds hit_count
module priority_encoder_scan
    import prio_scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = clog2_safe(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_none,
    output logic             out_last,
`ifdef PRIO_SCAN_POPCNT_EN
    output logic [IDX_W:0]   hit_count,
`endif
    output logic             busy
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic               zero_q, zero_d;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic               single;

    priority_encoder_n #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_enc (
        .req (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Exactly one bit left: clearing the lowest set bit leaves nothing
    assign single = enc_any && ((pending_q & (pending_q - WIDTH'(1))) == '0);

    // Outputs decode only from registered state, never from in_*
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SCAN);
        busy      = out_valid;
        out_idx   = (out_valid && !zero_q) ? enc_idx : '0;
        out_none  = out_valid && zero_q;
        out_last  = out_valid && (zero_q || single);
    end

    // Capture in IDLE; in SCAN retire the current bit on each accepted beat
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = zero_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                pending_d = in_data;
                zero_d    = (in_data == '0);
                state_d   = SCAN;
            end
        end else if (out_ready) begin
            pending_d = pending_q & ~(WIDTH'(1) << out_idx);
            state_d   = out_last ? IDLE : SCAN;
        end
    end

    // State and scan registers; reset discards any scan in progress at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

`ifdef PRIO_SCAN_POPCNT_EN
    logic [IDX_W:0] pop;
    logic [IDX_W:0] cnt_q;

    // Popcount of the vector being offered, latched only on capture
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (IDX_W+1)'(in_data[i]);
    end

    // Hold the count of the captured vector until the next capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (in_ready && in_valid) cnt_q <= pop;
    end

    assign hit_count = cnt_q;
`endif

endmodule

// File: doc/priority_encoder_scan.md
Name: priority_encoder_scan

Overview:
Parametrised, sequential successor to the fixed 8-to-3 priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake and then emits the index of every set bit, one per accepted output beat, in priority order. Each emitted bit is cleared from an internal pending register. An all-zero vector produces an explicit "none" beat instead of an ambiguous index 0. The block sits between request sources (interrupt lines, hit vectors) and a consumer that must service every active request, not just the highest one.

Parameters:
WIDTH, 8, number of request bits; legal range 2..256.
IDX_W, $clog2(WIDTH), index width; derived, never overridden.
MSB_FIRST, 1, 1 = highest set bit has priority; 0 = lowest set bit has priority.

Ports:
clk  input  1  clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request vector offered.
in_ready  output  1  block can accept a vector; high only in IDLE.
in_data  input  WIDTH  request vector.
out_valid  output  1  out_idx/out_none/out_last are valid.
out_ready  input  1  consumer accepts the current beat.
out_idx  output  IDX_W  index of the current highest-priority pending bit.
out_none  output  1  the captured vector was all-zero.
out_last  output  1  final beat for the captured vector.
busy  output  1  high in SCAN.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, rst.
- Reset values: state = IDLE, pending = 0, zero_flag = 0, in_ready = 1, out_valid = 0, out_idx = 0, out_none = 0, out_last = 0, busy = 0.
- Assertion of rst takes effect immediately, including mid-scan. Pending bits are discarded and no further beats are emitted.
- All outputs are decoded from state and registers only. No combinational path runs from in_* to out_*.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - When in_valid is high, capture pending <= in_data and zero_flag <= (in_data == 0), then go to SCAN.
- State SCAN:
  - out_valid = 1, in_ready = 0, busy = 1.
  - out_idx = priority index of pending (selected by MSB_FIRST). Forced to 0 when zero_flag is set.
  - out_none = zero_flag.
  - out_last = zero_flag, or pending has exactly one bit set.
  - On out_valid && out_ready: clear the bit at out_idx. If out_last, go to IDLE; otherwise stay in SCAN.
- Latency and throughput:
  - The first beat appears the cycle after the input handshake.
  - One index per cycle while out_ready is held high.
  - One bubble cycle in IDLE between vectors.
  - An N-hot vector takes N+1 cycles from accept to in_ready high again.
- Backpressure: while out_ready is low, out_idx, out_none and out_last hold stable and pending is unchanged.
- in_valid while busy: ignored; in_ready stays 0; nothing is captured.
- All-ones vector: exactly WIDTH beats, indices strictly monotonic.
- WIDTH not a power of two: indices never exceed WIDTH-1.

Optional Feature:
PRIO_SCAN_POPCNT_EN
- Defined: adds output hit_count [IDX_W:0].
  - Holds the popcount of the captured vector from the cycle after capture until the next capture.
  - Value is 0 for an all-zero vector; reset value is 0.
- Undefined: port and popcount logic are absent. All other behaviour is identical.

Decomposition:
- Package prio_scan_pkg:
  - state enum state_t {IDLE, SCAN}.
  - Function clog2-safe helper for IDX_W.
- Sub-module priority_encoder_n:
  - Combinational.
  - Parameters WIDTH and MSB_FIRST.
  - Outputs idx [IDX_W-1:0] and any.
  - Instantiated once on pending. Also reusable standalone.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, in_data=8'b1010_0100, out_ready=1 -> out_idx 7, 5, 2 on consecutive cycles; out_last only on idx 2; in_ready=1 the following cycle.
2. in_data=8'h00 -> single beat with out_none=1, out_idx=0, out_last=1; hit_count=0 when PRIO_SCAN_POPCNT_EN is defined.
3. in_data=8'h81, out_ready low for 3 cycles after first out_valid -> out_idx=7 held stable for 4 cycles; then idx 0 with out_last=1.
4. in_data=8'h0F accepted, then in_valid=1 with in_data=8'hF0 during SCAN -> only 3, 2, 1, 0 emitted; 8'hF0 accepted in the first IDLE cycle after; then 7, 6, 5, 4.
5. rst asserted mid-cycle during a scan of 8'hFF after 2 beats -> out_valid=0 and in_ready=1 immediately; after release, no stale beats appear.
6. WIDTH=12, MSB_FIRST=0, in_data=12'h801 -> out_idx 0, then 11 with out_last=1; all-ones 12'hFFF gives exactly 12 beats, 0..11.
